// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, one byte per 8N1 frame (8E1/8O1 when UART_TX_PARITY_EN is defined), LSB first.
// Latency: txd goes low the cycle after acceptance; done pulses 10*BPS_CNT clocks (11*BPS_CNT with parity) after acceptance.
// Backpressure: uart_tx_ready is low for the whole frame; uart_tx_en is ignored while ready is low.
//
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit between the data bits and the stop bit.
//
// Ports:
//   sys_clk        in   system clock, all logic on the rising edge
//   sys_rst_n      in   synchronous active-low reset
//   uart_tx_en     in   request valid, byte on uart_tx_data is offered
//   uart_tx_data   in   byte to send, sampled only at acceptance
//   uart_tx_ready  out  high when idle and able to accept a byte
//   uart_tx_done   out  one-cycle pulse at the end of the stop bit
//   uart_txd       out  serial line, registered, idle high
module uart_tx #(
  parameter int BPS         = 9600,
  parameter int SYS_CLK_FRE = 100_000_000,
  parameter int PARITY_ODD  = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_tx_en,
  input  logic [7:0] uart_tx_data,
  output logic       uart_tx_ready,
  output logic       uart_tx_done,
  output logic       uart_txd
);

  localparam int          BPS_CNT  = SYS_CLK_FRE / BPS;
  localparam logic [15:0] CNT_LAST = 16'(BPS_CNT - 1);

  // The bit counter is 16 bits wide; reject parameter sets it cannot count.
  if (BPS_CNT < 1 || BPS_CNT > 65535 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx: unsupported parameters (BPS_CNT must be 1..65535, PARITY_ODD 0 or 1)");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // Registered state
  state_t      r_state;
  logic [15:0] r_clk_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_txd;
  logic        r_ready;
  logic        r_done;

  // Next-state values
  state_t      w_state_nxt;
  logic [15:0] w_clk_cnt_nxt;
  logic [2:0]  w_bit_idx_nxt;
  logic [7:0]  w_shift_nxt;
  logic        w_txd_nxt;
  logic        w_ready_nxt;
  logic        w_done_nxt;

  logic        w_accept;
  logic        w_bit_end;

  // r_ready is only high in IDLE, so it doubles as the acceptance qualifier.
  assign w_accept  = uart_tx_en && r_ready;
  assign w_bit_end = (r_clk_cnt == CNT_LAST);

`ifdef UART_TX_PARITY_EN
  logic w_parity;
  // Even parity makes the total count of ones even; odd sense flips it.
  assign w_parity = (^r_shift) ^ (PARITY_ODD != 0);
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_txd     <= 1'b1;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_txd     <= w_txd_nxt;
      r_ready   <= w_ready_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Outputs are registered: every value computed here appears on the
  // pins the cycle after the edge that loads it, so each state's line
  // level is loaded on the boundary edge that enters that state.
  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_txd_nxt     = r_txd;
    w_ready_nxt   = r_ready;
    w_done_nxt    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_txd_nxt     = 1'b1;
        w_ready_nxt   = 1'b1;
        w_clk_cnt_nxt = 16'd0;
        w_bit_idx_nxt = 3'd0;
        if (w_accept) begin
          w_shift_nxt = uart_tx_data;
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
          w_ready_nxt = 1'b0;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_clk_cnt_nxt = 16'd0;
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = S_DATA;
          w_txd_nxt     = r_shift[0];
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 16'd1;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_clk_cnt_nxt = 16'd0;
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_nxt = 3'd0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt   = S_PARITY;
            w_txd_nxt     = w_parity;
`else
            w_state_nxt   = S_STOP;
            w_txd_nxt     = 1'b1;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_txd_nxt     = r_shift[r_bit_idx + 3'd1];
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 16'd1;
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_clk_cnt_nxt = 16'd0;
          w_state_nxt   = S_STOP;
          w_txd_nxt     = 1'b1;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 16'd1;
        end
      end
`endif

      S_STOP: begin
        w_txd_nxt = 1'b1;
        if (w_bit_end) begin
          // Ready and done rise together so a waiting byte can be
          // accepted on the very next edge (one idle-high clock gap).
          w_clk_cnt_nxt = 16'd0;
          w_state_nxt   = S_IDLE;
          w_ready_nxt   = 1'b1;
          w_done_nxt    = 1'b1;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 16'd1;
        end
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_clk_cnt_nxt = 16'd0;
        w_bit_idx_nxt = 3'd0;
        w_txd_nxt     = 1'b1;
        w_ready_nxt   = 1'b1;
      end
    endcase
  end

  assign uart_txd      = r_txd;
  assign uart_tx_ready = r_ready;
  assign uart_tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx.
// Runs with 10 clocks per bit; the line is sampled on falling edges.
// Expected frames come from a simple bit-list model of the frame format.
module tb_uart_tx;

  localparam int SYS_CLK = 1_000_000;
  localparam int BAUD    = 100_000;
  localparam int B       = SYS_CLK / BAUD;
  localparam int PAR_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS   = 11;
`else
  localparam int NBITS   = 10;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_ready;
  logic       uart_tx_done;
  logic       uart_txd;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx #(
    .BPS(BAUD),
    .SYS_CLK_FRE(SYS_CLK),
    .PARITY_ODD(PAR_ODD)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .uart_tx_en(uart_tx_en),
    .uart_tx_data(uart_tx_data),
    .uart_tx_ready(uart_tx_ready),
    .uart_tx_done(uart_tx_done),
    .uart_txd(uart_txd)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Line level of bit k of the frame carrying byte d.
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    logic [10:0] f;
`ifdef UART_TX_PARITY_EN
    logic par;
    par = (^d) ^ (PAR_ODD != 0);
    f = {1'b1, par, d, 1'b0};
`else
    f = {2'b11, d, 1'b0};
`endif
    return f[k];
  endfunction

  // Idle for n cycles: line high, ready high, no done.
  task automatic idle(input int n, input string name);
    int bad;
    bad = 0;
    uart_tx_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      if (uart_txd !== 1'b1 || uart_tx_ready !== 1'b1 || uart_tx_done !== 1'b0) bad++;
    end
    check({name, "_idle"}, bad, 0);
  endtask

  // Called at a falling edge with en=1 and data=d already driven.
  // mode: 0 en low during frame, 1 random en, 2 en held high.
  // pulse_at: cycle after acceptance at which en is pulsed with 0xFF.
  task automatic run_frame(input logic [7:0] d, input int mode, input int pulse_at, input string name);
    int bad;
    logic [B-1:0] samp;
    logic [B-1:0] exp;
    check({name, "_rdy_pre"}, uart_tx_ready, 1);
    @(posedge sys_clk);
    bad = 0;
    for (int k = 0; k < NBITS; k++) begin
      for (int c = 0; c < B; c++) begin
        @(negedge sys_clk);
        samp[c] = uart_txd;
        if (uart_tx_ready !== 1'b0 || uart_tx_done !== 1'b0) bad++;
        uart_tx_data = 8'($urandom);
        case (mode)
          0:       uart_tx_en = 1'b0;
          1:       uart_tx_en = 1'($urandom_range(0, 1));
          default: uart_tx_en = 1'b1;
        endcase
        if (k * B + c == pulse_at) begin
          uart_tx_en   = 1'b1;
          uart_tx_data = 8'hFF;
        end
      end
      exp = frame_bit(d, k) ? '1 : '0;
      check($sformatf("%s_bit%0d", name, k), samp, exp);
    end
    check({name, "_busy_flags"}, bad, 0);
    @(negedge sys_clk);
    check({name, "_done"}, uart_tx_done, 1);
    check({name, "_rdy_done"}, uart_tx_ready, 1);
    check({name, "_txd_done"}, uart_txd, 1);
    uart_tx_en = 1'b0;
  endtask

  // Start a frame and reset during data bit 3.
  task automatic abort_frame(input logic [7:0] d, input string name);
    uart_tx_data = d;
    uart_tx_en   = 1'b1;
    @(posedge sys_clk);
    for (int j = 0; j <= 4 * B + 3; j++) begin
      @(negedge sys_clk);
      uart_tx_en = 1'b0;
    end
    check({name, "_txd_pre_rst"}, uart_txd, frame_bit(d, 4));
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check({name, "_rst_txd"}, uart_txd, 1);
    check({name, "_rst_rdy"}, uart_tx_ready, 1);
    check({name, "_rst_done"}, uart_tx_done, 0);
    sys_rst_n = 1'b1;
    idle(12 * B, name);
  endtask

  initial begin
    logic [7:0] d;
    sys_rst_n    = 1'b0;
    uart_tx_en   = 1'b0;
    uart_tx_data = 8'h00;
    repeat (2) @(negedge sys_clk);
    check("rst_txd", uart_txd, 1);
    check("rst_rdy", uart_tx_ready, 1);
    check("rst_done", uart_tx_done, 0);
    sys_rst_n = 1'b1;
    idle(3, "post_rst");

    // 0x55: alternating line levels.
    uart_tx_data = 8'h55; uart_tx_en = 1'b1;
    run_frame(8'h55, 0, -1, "t1");
    idle(2, "t1");

    // 0xA3 with en held high, then 0x0F offered in the done cycle.
    uart_tx_data = 8'hA3; uart_tx_en = 1'b1;
    run_frame(8'hA3, 2, -1, "t2a");
    uart_tx_data = 8'h0F; uart_tx_en = 1'b1;
    run_frame(8'h0F, 0, -1, "t2b");
    idle(3, "t2");

    // 0xFF pulse at cycle 30 of a 0x00 frame is ignored.
    uart_tx_data = 8'h00; uart_tx_en = 1'b1;
    run_frame(8'h00, 0, 29, "t3");
    idle(2 * B, "t3");

    // Reset mid-frame, then a normal frame.
    abort_frame(8'hC6, "t4");
    uart_tx_data = 8'h3C; uart_tx_en = 1'b1;
    run_frame(8'h3C, 0, -1, "t4b");
    idle(2, "t4b");

    // Random bytes, random en noise, random back-to-back.
    d = 8'($urandom);
    uart_tx_data = d; uart_tx_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      run_frame(d, int'($urandom_range(0, 2)), -1, $sformatf("r%0d", i));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 4)), $sformatf("r%0d", i));
      d = 8'($urandom);
      uart_tx_data = d;
      uart_tx_en   = 1'b1;
    end
    run_frame(d, 0, -1, "rlast");
    idle(5, "end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: serialises one 8-bit byte per frame onto `uart_txd`.
- Frame format is 8N1, LSB first: 1 start bit (0), 8 data bits, 1 stop bit (1).
- Pairs with the UART receive path; shares its baud parameters and clocking (100 MHz system clock, 9600 bps default).
- Upstream logic hands bytes over with a valid/ready handshake. Completion is reported with a one-cycle done pulse.

Parameters:
- BPS, 9600, baud rate in bits per second.
- SYS_CLK_FRE, 100_000_000, system clock frequency in Hz.
- BPS_CNT (localparam), SYS_CLK_FRE/BPS truncated, clocks per bit; 10416 at defaults.
- PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst_n  in  1  synchronous active-low reset.
- uart_tx_en  in  1  request valid: byte on uart_tx_data is offered.
- uart_tx_data  in  8  byte to send; sampled only at acceptance.
- uart_tx_ready  out  1  high when idle and able to accept a byte.
- uart_tx_done  out  1  one-cycle pulse at end of stop bit.
- uart_txd  out  1  serial line, registered, idle high.

Behaviour:
- Reset (sys_rst_n low at a rising edge, any state):
  - uart_txd=1, uart_tx_ready=1, uart_tx_done=0.
  - State IDLE; bit counter and clk_cnt = 0; shift register = 0.
  - Reset mid-frame aborts the frame; the line returns high on that same edge.
- Handshake:
  - A byte is accepted at a rising edge where uart_tx_en=1 and uart_tx_ready=1.
  - uart_tx_data is latched into the shift register on that edge.
  - uart_tx_ready drops to 0 on that edge.
  - uart_tx_en while ready=0 is ignored. uart_tx_data changes after acceptance have no effect.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: uart_txd=1.
  - On acceptance go to START; uart_txd=0 from the acceptance edge (visible the cycle after the edge).
  - Each non-IDLE state holds uart_txd for exactly BPS_CNT clocks. clk_cnt counts 0..BPS_CNT-1 and wraps to 0 on each bit boundary.
  - DATA: 8 bits, bit index 0..7, uart_txd = shift register bit index (LSB first). The index increments at each bit boundary; after index 7 go to STOP, or to PARITY if the macro is defined.
  - STOP: uart_txd=1 for BPS_CNT clocks.
- End of frame (edge where STOP has clk_cnt=BPS_CNT-1):
  - Go to IDLE; uart_tx_done=1 for exactly one cycle; uart_tx_ready=1 in the same cycle.
- Back-to-back: if uart_tx_en=1 in the cycle ready returns high, the next byte is accepted on the following edge. The gap after the stop bit is 1 clock of idle-high only.
- Frame length: acceptance edge to done pulse = 10*BPS_CNT clocks (11*BPS_CNT with parity). No other output toggles during a frame.
- Width: clk_cnt is 16 bits, sufficient for BPS_CNT ≤ 65535; parameter sets exceeding this are unsupported.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP, lasting BPS_CNT clocks.
  - Parity bit = XOR of the 8 latched data bits, inverted when PARITY_ODD=1.
  - Frame becomes 8E1/8O1, 11 bits.
- Undefined: no PARITY state or logic; 8N1 frame; PARITY_ODD unused.

Test Plan:
1. SYS_CLK_FRE=1_000_000, BPS=100_000 (BPS_CNT=10). Send 0x55 -> uart_txd levels 0,1,0,1,0,1,0,1,0,1, each held 10 clocks; done pulses 100 clocks after acceptance, width 1; ready=1 in that cycle.
2. Same params. Send 0xA3 with uart_tx_en held high, then 0x0F presented at the done cycle -> second start bit begins 1 clock after done; bits 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0; no extra idle.
3. Pulse uart_tx_en with 0xFF at cycle 30 of a frame carrying 0x00 -> ignored; line shows only 0x00 frame; one done pulse.
4. Assert sys_rst_n=0 for one clock during data bit 3 -> on that edge uart_txd=1, ready=1, done=0; no done pulse follows; a new byte is accepted normally afterwards.
5. UART_TX_PARITY_EN defined, PARITY_ODD=0. Send 0x07 -> parity bit 1, frame 110 clocks. With PARITY_ODD=1 -> parity bit 0.
6. Defaults (BPS_CNT=10416). Send 0x00 -> uart_txd low for 93744 clocks (start + 8 data), high stop 10416 clocks, done at 104160 clocks.
